// File: rtl/usb_pid_pkg.sv
// USB PID codes, class encoding and idle byte shared by the PID tracker.
// Build option: define USB_PID_STATS_EN to add the saturating error counter.
package usb_pid_pkg;

   typedef enum logic [3:0] {
      PID_OUT   = 4'h1,
      PID_ACK   = 4'h2,
      PID_DATA0 = 4'h3,
      PID_SOF   = 4'h5,
      PID_IN    = 4'h9,
      PID_NAK   = 4'hA,
      PID_DATA1 = 4'hB,
      PID_SETUP = 4'hD,
      PID_STALL = 4'hE
   } pid_e;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_TOKEN  = 2'd1,
      CLS_DATA   = 2'd2,
      CLS_HSHAKE = 2'd3
   } pid_cls_e;

   localparam logic [7:0] PID_BYTE_IDLE = 8'hFF;

   function automatic pid_cls_e pid_class(input logic [3:0] nib);
      pid_cls_e c;
      c = CLS_NONE;
      case (nib)
         PID_OUT, PID_IN, PID_SOF, PID_SETUP: c = CLS_TOKEN;
         PID_DATA0, PID_DATA1:                c = CLS_DATA;
         PID_ACK, PID_NAK, PID_STALL:         c = CLS_HSHAKE;
         default:                             c = CLS_NONE;
      endcase
      return c;
   endfunction

   function automatic logic pid_byte_ok(input logic [7:0] b,
                                        input logic [15:0] mask);
      return (b[7:4] == ~b[3:0]) && mask[b[3:0]];
   endfunction

endpackage

// File: rtl/pid_toggle_bank.sv
// Per-endpoint expected DATA0/DATA1 toggle flops with advance/clear update.
// Out-of-range endpoint selects read as DATA0 and ignore updates.
module pid_toggle_bank
   import usb_pid_pkg::*;
#(
   parameter int NUM_EP = 4,
   parameter int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic [EP_W-1:0] ep_sel,
   input  logic            toggle_adv,
   input  logic            toggle_clr,
   output logic            ep_ok,
   output logic            exp_tog
);

   logic [NUM_EP-1:0] tog;

   assign ep_ok = (32'(ep_sel) < NUM_EP);

   always_comb begin
      exp_tog = 1'b0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (ep_sel == EP_W'(i)) exp_tog = tog[i];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tog <= '0;
      end else begin
         for (int i = 0; i < NUM_EP; i++) begin
            if (ep_sel == EP_W'(i)) begin
               if (toggle_clr)      tog[i] <= 1'b0;
               else if (toggle_adv) tog[i] <= ~tog[i];
            end
         end
      end
   end

endmodule

// File: rtl/pid_check_tracker.sv
// USB RX PID capture, validation, class decode and data-toggle checking.
// Build option: USB_PID_STATS_EN adds err_count / err_cnt_clr.
module pid_check_tracker
   import usb_pid_pkg::*;
#(
   parameter int          NUM_EP       = 4,
   parameter int          EP_W         = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
   parameter logic [15:0] ALLOWED_PIDS = 16'h6E0E
`ifdef USB_PID_STATS_EN
   ,
   parameter int          CNT_W        = 8
`endif
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [7:0]       rcv_data,
   input  logic             pid_set,
   input  logic             pid_clear,
   input  logic [EP_W-1:0]  ep_sel,
   input  logic             toggle_adv,
   input  logic             toggle_clr,
   output logic [3:0]       pid,
   output logic             pid_valid,
   output logic             pid_err,
   output logic             is_token,
   output logic             is_data,
   output logic             is_hshake,
   output logic             toggle_err
`ifdef USB_PID_STATS_EN
   ,
   output logic [CNT_W-1:0] err_count,
   input  logic             err_cnt_clr
`endif
);

   logic [7:0] pid_byte;
   logic       ep_ok;
   logic       exp_tog;
   logic       new_ok;
   logic       new_data;
   logic       tog_err_d;
   pid_cls_e   cls;

   pid_toggle_bank #(
      .NUM_EP (NUM_EP),
      .EP_W   (EP_W)
   ) u_bank (
      .clk        (clk),
      .n_rst      (n_rst),
      .ep_sel     (ep_sel),
      .toggle_adv (toggle_adv),
      .toggle_clr (toggle_clr),
      .ep_ok      (ep_ok),
      .exp_tog    (exp_tog)
   );

   // Check of the incoming byte uses the pre-update toggle value.
   assign new_ok    = pid_byte_ok(rcv_data, ALLOWED_PIDS);
   assign new_data  = (pid_class(rcv_data[3:0]) == CLS_DATA);
   assign tog_err_d = new_ok && new_data && ep_ok &&
                      (rcv_data[3] != exp_tog);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pid_byte   <= PID_BYTE_IDLE;
         pid_valid  <= 1'b0;
         toggle_err <= 1'b0;
      end else if (pid_set) begin
         pid_byte   <= rcv_data;
         pid_valid  <= 1'b1;
         toggle_err <= tog_err_d;
      end else if (pid_clear) begin
         pid_byte   <= PID_BYTE_IDLE;
         pid_valid  <= 1'b0;
         toggle_err <= 1'b0;
      end
   end

   assign pid     = pid_byte[3:0];
   assign pid_err = !pid_valid ||
                    !pid_byte_ok(pid_byte, ALLOWED_PIDS);
   assign cls     = pid_class(pid_byte[3:0]);

   always_comb begin
      is_token  = 1'b0;
      is_data   = 1'b0;
      is_hshake = 1'b0;
      if (!pid_err) begin
         unique case (1'b1)
            (cls == CLS_TOKEN):  is_token  = 1'b1;
            (cls == CLS_DATA):   is_data   = 1'b1;
            (cls == CLS_HSHAKE): is_hshake = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef USB_PID_STATS_EN
   logic cnt_inc;

   assign cnt_inc = pid_set && (!new_ok || tog_err_d);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err_count <= '0;
      end else if (err_cnt_clr) begin
         err_count <= '0;
      end else if (cnt_inc && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end
`endif

endmodule
